// File: rtl/pipe_pkg.sv
// Shared constants for the pipe_stage_skid slice: reset PC, exception codes
// and the encoded occupancy states (bit0 = main valid, bit1 = skid valid).
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    localparam int EX_W_DEF = 5;
    localparam logic [EX_W_DEF-1:0] EX_NONE = '0;

    typedef logic [1:0] state_t;

    localparam state_t ST_EMPTY = 2'b00;
    localparam state_t ST_ONE   = 2'b01;
    localparam state_t ST_TWO   = 2'b11;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Ready/valid stream carrying one pipeline entry (PC, payload, exception, delay-slot flag).
interface pipe_stage_skid_if #(
  parameter int DATA_W = 64,
  parameter int PC_W   = 32,
  parameter int EX_W   = 5
);
  logic              valid;
  logic              ready;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] data;
  logic [EX_W-1:0]   ex;
  logic              bd;

  modport master (output valid, pc, data, ex, bd, input ready);
  modport slave  (input valid, pc, data, ex, bd, output ready);
endinterface

// File: rtl/pipe_entry_reg.sv
// One stored pipeline entry with load enable; reset loads RESET_PC and zeros.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int              DATA_W   = 64,
  parameter int              PC_W     = 32,
  parameter int              EX_W     = 5,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF[PC_W-1:0]
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [DATA_W-1:0] d_data,
  input  logic [EX_W-1:0]   d_ex,
  input  logic              d_bd,
  output logic [PC_W-1:0]   q_pc,
  output logic [DATA_W-1:0] q_data,
  output logic [EX_W-1:0]   q_ex,
  output logic              q_bd
);
  always_ff @(posedge clk) begin
    if (reset) begin
      q_pc   <= RESET_PC;
      q_data <= '0;
      q_ex   <= EX_NONE[EX_W-1:0];
      q_bd   <= 1'b0;
    end else if (load) begin
      q_pc   <= d_pc;
      q_data <= d_data;
      q_ex   <= d_ex;
      q_bd   <= d_bd;
    end
  end
endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry ready/valid skid stage with registered in_ready, flush and post-reset marker.
// Optional PIPE_STAGE_BUBBLE_CNT_EN adds a saturating count of cycles with out_valid=0.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int              DATA_W   = 64,
  parameter int              PC_W     = 32,
  parameter int              EX_W     = EX_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF[PC_W-1:0]
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  pipe_stage_skid_if.slave  in_if,
  pipe_stage_skid_if.master out_if,
  output logic              out_res
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  ,
  output logic [31:0]       bubble_cnt
`endif
);
  localparam int IDX_M = 0;
  localparam int IDX_S = 1;

  state_t state_reg, state_next;
  logic   in_ready_reg;
  logic   out_res_reg;
  logic   acc, dep, mv;
  logic   m_load, s_load, m_from_skid;

  logic              entry_load [2];
  logic [PC_W-1:0]   entry_d_pc [2];
  logic [DATA_W-1:0] entry_d_data [2];
  logic [EX_W-1:0]   entry_d_ex [2];
  logic              entry_d_bd [2];
  logic [PC_W-1:0]   entry_q_pc [2];
  logic [DATA_W-1:0] entry_q_data [2];
  logic [EX_W-1:0]   entry_q_ex [2];
  logic              entry_q_bd [2];

  assign mv  = state_reg[0];
  assign acc = in_if.valid & in_ready_reg;
  assign dep = mv & out_if.ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_EMPTY;
      in_ready_reg <= 1'b1;
      out_res_reg  <= 1'b1;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != ST_TWO);
      if (acc && !flush)
        out_res_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: if (acc) state_next = ST_ONE;
        ST_ONE: begin
          if (acc && !dep)      state_next = ST_TWO;
          else if (!acc && dep) state_next = ST_EMPTY;
        end
        ST_TWO:   if (dep) state_next = ST_ONE;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  // Flush suppresses every payload load, so held fields stay as they were.
  always_comb begin
    m_load      = 1'b0;
    s_load      = 1'b0;
    m_from_skid = 1'b0;
    if (!flush) begin
      case (state_reg)
        ST_EMPTY: m_load = acc;
        ST_ONE: begin
          m_load = acc & dep;
          s_load = acc & ~dep;
        end
        ST_TWO: begin
          m_load      = dep;
          m_from_skid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign entry_load[IDX_M]   = m_load;
  assign entry_load[IDX_S]   = s_load;
  assign entry_d_pc[IDX_M]   = m_from_skid ? entry_q_pc[IDX_S]   : in_if.pc;
  assign entry_d_data[IDX_M] = m_from_skid ? entry_q_data[IDX_S] : in_if.data;
  assign entry_d_ex[IDX_M]   = m_from_skid ? entry_q_ex[IDX_S]   : in_if.ex;
  assign entry_d_bd[IDX_M]   = m_from_skid ? entry_q_bd[IDX_S]   : in_if.bd;
  assign entry_d_pc[IDX_S]   = in_if.pc;
  assign entry_d_data[IDX_S] = in_if.data;
  assign entry_d_ex[IDX_S]   = in_if.ex;
  assign entry_d_bd[IDX_S]   = in_if.bd;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      pipe_entry_reg #(
        .DATA_W   (DATA_W),
        .PC_W     (PC_W),
        .EX_W     (EX_W),
        .RESET_PC (RESET_PC)
      ) u_entry (
        .clk    (clk),
        .reset  (reset),
        .load   (entry_load[gi]),
        .d_pc   (entry_d_pc[gi]),
        .d_data (entry_d_data[gi]),
        .d_ex   (entry_d_ex[gi]),
        .d_bd   (entry_d_bd[gi]),
        .q_pc   (entry_q_pc[gi]),
        .q_data (entry_q_data[gi]),
        .q_ex   (entry_q_ex[gi]),
        .q_bd   (entry_q_bd[gi])
      );
    end
  endgenerate

  assign in_if.ready  = in_ready_reg;
  assign out_if.valid = mv;
  assign out_if.pc    = entry_q_pc[IDX_M];
  assign out_if.data  = entry_q_data[IDX_M];
  assign out_if.ex    = entry_q_ex[IDX_M];
  assign out_if.bd    = entry_q_bd[IDX_M];
  assign out_res      = out_res_reg;

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset)
      bubble_cnt_reg <= '0;
    else if (!mv && bubble_cnt_reg != 32'hFFFF_FFFF)
      bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
  end

  assign bubble_cnt = bubble_cnt_reg;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, back-pressure, flush, reset-over-flush.
// Also checks bubble_cnt when PIPE_STAGE_BUBBLE_CNT_EN is defined.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DATA_W = 64;
  localparam int PC_W   = 32;
  localparam int EX_W   = 5;

  logic clk = 1'b0;
  logic reset, flush, out_res;
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_skid_if #(.DATA_W(DATA_W), .PC_W(PC_W), .EX_W(EX_W)) in_if ();
  pipe_stage_skid_if #(.DATA_W(DATA_W), .PC_W(PC_W), .EX_W(EX_W)) out_if ();

  pipe_stage_skid #(
    .DATA_W   (DATA_W),
    .PC_W     (PC_W),
    .EX_W     (EX_W),
    .RESET_PC (32'h0000_3000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .in_if   (in_if.slave),
    .out_if  (out_if.master),
    .out_res (out_res)
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Payload fields are derived from the PC so each entry is recognisable.
  function automatic logic [63:0] data_of(input logic [31:0] pc);
    return {32'hDA7A_0000 | {16'h0, pc[15:0]}, ~pc};
  endfunction

  function automatic logic [4:0] ex_of(input logic [31:0] pc);
    return pc[6:2] ^ 5'h15;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc);
    in_if.valid = v;
    in_if.pc    = pc;
    in_if.data  = data_of(pc);
    in_if.ex    = ex_of(pc);
    in_if.bd    = pc[2];
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, {63'd0, out_if.valid}, 64'd1);
    check({tag, ".pc"},    {32'd0, out_if.pc}, {32'd0, pc});
    check({tag, ".data"},  out_if.data, data_of(pc));
    check({tag, ".ex"},    {59'd0, out_if.ex}, {59'd0, ex_of(pc)});
    check({tag, ".bd"},    {63'd0, out_if.bd}, {63'd0, pc[2]});
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_if.ready = 1'b1;
    drive(1'b1, 32'h0000_1234);
    tick();
    tick();
    check("rst.out_valid", {63'd0, out_if.valid}, 64'd0);
    check("rst.out_pc",    {32'd0, out_if.pc}, 64'h3000);
    check("rst.out_data",  out_if.data, 64'd0);
    check("rst.out_ex",    {59'd0, out_if.ex}, 64'd0);
    check("rst.out_res",   {63'd0, out_res}, 64'd1);
    check("rst.in_ready",  {63'd0, in_if.ready}, 64'd1);

    // Four idle cycles, then a three-entry stream at full rate.
    reset = 1'b0;
    drive(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    drive(1'b1, 32'h3000);
    tick();
    check_out("stream0", 32'h3000);
    check("stream0.out_res",  {63'd0, out_res}, 64'd0);
    check("stream0.in_ready", {63'd0, in_if.ready}, 64'd1);
    drive(1'b1, 32'h3004);
    tick();
    check_out("stream1", 32'h3004);
    check("stream1.in_ready", {63'd0, in_if.ready}, 64'd1);
    drive(1'b1, 32'h3008);
    tick();
    check_out("stream2", 32'h3008);
    check("stream2.in_ready", {63'd0, in_if.ready}, 64'd1);
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    check("bubble.after_stream", {32'd0, bubble_cnt}, 64'd5);
`endif
    drive(1'b0, 32'h0);
    tick();
    check("drain.out_valid", {63'd0, out_if.valid}, 64'd0);
    check("drain.out_pc_last", {32'd0, out_if.pc}, 64'h3008);

    // Back-pressure fills main then skid; extra offer must be refused.
    out_if.ready = 1'b0;
    drive(1'b1, 32'h3000);
    tick();
    check_out("bp.one", 32'h3000);
    drive(1'b1, 32'h3004);
    tick();
    check_out("bp.two", 32'h3000);
    check("bp.two.in_ready", {63'd0, in_if.ready}, 64'd0);
    drive(1'b1, 32'h3008);
    tick();
    check_out("bp.hold", 32'h3000);
    check("bp.hold.in_ready", {63'd0, in_if.ready}, 64'd0);
    drive(1'b0, 32'h0);
    out_if.ready = 1'b1;
    tick();
    check_out("bp.rel1", 32'h3004);
    check("bp.rel1.in_ready", {63'd0, in_if.ready}, 64'd1);
    tick();
    check("bp.rel2.out_valid", {63'd0, out_if.valid}, 64'd0);

    // Flush in TWO with a same-cycle offer.
    out_if.ready = 1'b0;
    drive(1'b1, 32'h4000);
    tick();
    drive(1'b1, 32'h4004);
    tick();
    check("fl.pre.in_ready", {63'd0, in_if.ready}, 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h4008);
    tick();
    check("fl.out_valid", {63'd0, out_if.valid}, 64'd0);
    check("fl.in_ready",  {63'd0, in_if.ready}, 64'd1);
    check("fl.out_res",   {63'd0, out_res}, 64'd0);
    check("fl.out_pc_kept", {32'd0, out_if.pc}, 64'h4000);
    flush = 1'b0;
    out_if.ready = 1'b1;
    drive(1'b1, 32'h4180);
    tick();
    check_out("fl.next", 32'h4180);
    drive(1'b0, 32'h0);
    tick();
    check("fl.drain.out_valid", {63'd0, out_if.valid}, 64'd0);

    // Reset while in TWO and flushing: reset values win, skid never emerges.
    out_if.ready = 1'b0;
    drive(1'b1, 32'h5000);
    tick();
    drive(1'b1, 32'h5004);
    tick();
    check("rf.pre.in_ready", {63'd0, in_if.ready}, 64'd0);
    reset = 1'b1;
    flush = 1'b1;
    drive(1'b1, 32'h5008);
    tick();
    check("rf.out_valid", {63'd0, out_if.valid}, 64'd0);
    check("rf.out_pc",    {32'd0, out_if.pc}, 64'h3000);
    check("rf.out_res",   {63'd0, out_res}, 64'd1);
    check("rf.in_ready",  {63'd0, in_if.ready}, 64'd1);
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    check("bubble.reset", {32'd0, bubble_cnt}, 64'd0);
`endif
    reset = 1'b0;
    flush = 1'b0;
    out_if.ready = 1'b1;
    drive(1'b0, 32'h0);
    tick();
    check("rf.after1.out_valid", {63'd0, out_if.valid}, 64'd0);
    tick();
    check("rf.after2.out_valid", {63'd0, out_if.valid}, 64'd0);

    // A flushed acceptance must not clear out_res; the next real one does.
    flush = 1'b1;
    drive(1'b1, 32'h6000);
    tick();
    check("res.flushed_acc", {63'd0, out_res}, 64'd1);
    check("res.flushed_valid", {63'd0, out_if.valid}, 64'd0);
    flush = 1'b0;
    drive(1'b1, 32'h6004);
    tick();
    check("res.cleared", {63'd0, out_res}, 64'd0);
    check_out("res.entry", 32'h6004);
    drive(1'b0, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field stage registers. It is a two-entry ready/valid skid stage carrying PC, a generic payload word, the exception code and the branch-delay flag between pipeline stages.
- Replaces combinational lock fan-out with a registered in_ready, so full-rate flow continues under back-pressure. Adds a flush that has priority over everything except reset.
- Keeps the post-reset marker (out_res) used by the exception logic.

Parameters:
- DATA_W, 64, payload width (packed instruction plus control bits).
- PC_W, 32, PC width.
- EX_W, 5, exception-code width.
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries this cycle.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept; registered.
- in_pc  in  PC_W  entry PC.
- in_data  in  DATA_W  entry payload.
- in_ex  in  EX_W  entry exception code.
- in_bd  in  1  entry is in a delay slot.
- out_valid  out  1  main entry present.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_W  main-entry PC.
- out_data  out  DATA_W  main-entry payload.
- out_ex  out  EX_W  main-entry exception code.
- out_bd  out  1  main-entry delay-slot flag.
- out_res  out  1  high from reset until the first accepted entry.

Behaviour:
- Storage: main register M (drives all out_* payload) and skid register S, each with a valid bit (mv, sv). Encoded state:
  - EMPTY: mv=0, sv=0.
  - ONE: mv=1, sv=0.
  - TWO: mv=1, sv=1.
  - mv=0 with sv=1 is illegal.
- Handshake definitions: acc = in_valid & in_ready; dep = out_valid & out_ready.
- Outputs: in_ready = ~sv, taken from a flop with no combinational path from out_ready. out_valid = mv.
- Transitions when not reset and not flush:
  - EMPTY: acc -> ONE, M<=in.
  - ONE: acc & dep -> ONE, M<=in. acc & ~dep -> TWO, S<=in. ~acc & dep -> EMPTY. Otherwise hold.
  - TWO: dep -> ONE, M<=S. Otherwise hold. acc is impossible because in_ready=0.
- Order is preserved: the skid entry is always older than any new input.
- Latency: 1 cycle from acc in EMPTY to out_valid. Sustained throughput is 1 entry/cycle while out_ready=1.
- Payload stays stable while out_valid=1 and out_ready=0. Payload does not change without dep or reset.
- flush (reset=0): next state EMPTY, mv=sv=0.
  - Payload registers are unchanged.
  - A same-cycle acc is dropped; the producer sees the handshake but the entry is discarded.
  - A same-cycle dep still counts as delivered downstream.
  - in_ready=1 the cycle after.
- reset: mv=sv=0, in_ready=1, out_pc=RESET_PC, out_data=0, out_ex=0, out_bd=0, out_res=1. Reset overrides flush and any handshake, including mid-TWO.
- out_res: set by reset, cleared on the first acc that is not flushed, never set by flush.
- When out_valid=0, out_* fields show the last M contents; consumers must gate on out_valid.
- Widths are used as-is; no arithmetic is performed.

Optional Feature:
- Macro: PIPE_STAGE_BUBBLE_CNT_EN.
- Defined:
  - Adds output bubble_cnt [31:0], counting cycles with reset=0 and out_valid=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - RESET_PC default constant.
  - EX_W default and exception-code constants (EX_NONE=0).
  - State encoding localparams ST_EMPTY, ST_ONE, ST_TWO.
- One natural sub-module: pipe_entry_reg, a PC/data/ex/bd register with load enable and reset value. Instantiated twice (M, S).

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, out_pc=0x3000, out_res=1, in_ready=1.
- Streaming: out_ready=1, feed pc 0x3000,0x3004,0x3008 on consecutive cycles -> same pcs on out_pc one cycle later each, in_ready stays 1, out_res falls after the first acc.
- Back-pressure: out_ready=0, feed 0x3000,0x3004 -> state TWO, in_ready=0, out_pc holds 0x3000. Release out_ready -> 0x3000 then 0x3004 delivered in order, no loss or duplication.
- Flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_res stays 0. Subsequent input 0x4180 appears after 1 cycle.
- Reset mid-TWO while flush=1 -> reset values (out_res=1, out_pc=0x3000); skid entry never emerges.
- With PIPE_STAGE_BUBBLE_CNT_EN: 5 idle cycles after reset, then continuous flow -> bubble_cnt=5 and it stops incrementing.
